// File: rtl/magic_nor_seq_if.sv
// magic_nor_seq_if: input-vector, instruction and result handshakes
// master = program driver, slave = magic_nor_seq evaluator
interface magic_nor_seq_if #(
  parameter int N_IN   = 10,
  parameter int N_OUT  = 7,
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_vec;
  logic              ins_valid;
  logic              ins_ready;
  logic [1:0]        ins_op;
  logic [ADDR_W-1:0] ins_dst;
  logic [ADDR_W-1:0] ins_a;
  logic [ADDR_W-1:0] ins_b;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_vec;
  logic              busy;
  logic              err;

  modport master (
    output in_valid, in_vec,
    output ins_valid, ins_op,
    output ins_dst, ins_a, ins_b,
    output out_ready,
    input  in_ready, ins_ready,
    input  out_valid, out_vec,
    input  busy, err
  );

  modport slave (
    input  in_valid, in_vec,
    input  ins_valid, ins_op,
    input  ins_dst, ins_a, ins_b,
    input  out_ready,
    output in_ready, ins_ready,
    output out_valid, out_vec,
    output busy, err
  );
endinterface

// File: rtl/magic_nor_seq.sv
// magic_nor_seq: one-gate-at-a-time MAGIC-NOR evaluator of mapped
// inv1/nor2 programs over a 1-bit cell array.
// Ports: clk, rst_n (async, active-low); bus (magic_nor_seq_if.slave):
//   in_*  input vector, ins_* instruction stream (op/dst/a/b),
//   out_* result vector, busy, err (sticky illegal instruction).
// MAGIC_NOR_OPCOUNT_EN adds op_count[15:0], a saturating count of
// accepted legal NOR2/INV1 gates.
module magic_nor_seq #(
  parameter int N_IN    = 10,
  parameter int N_OUT   = 7,
  parameter int N_CELLS = 64,
  parameter int ADDR_W  = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  magic_nor_seq_if.slave bus
`ifdef MAGIC_NOR_OPCOUNT_EN
  ,
  output logic [15:0]   op_count
`endif
);

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_INV = 2'b01;
  localparam logic [1:0] OP_OUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EVAL,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [N_CELLS-1:0] cells;
  logic [ADDR_W-1:0]  dst_q, a_q, b_q;
  logic [ADDR_W-1:0]  src_b;
  logic               in_acc;
  logic               gate_ok;
  logic               out_ok;
  logic               bad;
  logic               is_gate;
  logic               is_out;

  function automatic logic in_rng(
    input logic [ADDR_W-1:0] x
  );
    return int'(x) < N_CELLS;
  endfunction

  assign is_gate = (bus.ins_op == OP_NOR) ||
                   (bus.ins_op == OP_INV);
  assign is_out  = (bus.ins_op == OP_OUT);
  assign src_b   = (bus.ins_op == OP_INV) ?
                   bus.ins_a : bus.ins_b;

  assign bus.in_ready  = (state == IDLE);
  assign bus.ins_ready = (state == FETCH);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_acc   = 1'b0;
    gate_ok  = 1'b0;
    out_ok   = 1'b0;
    bad      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          in_acc   = 1'b1;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        if (bus.ins_valid) begin
          unique case (1'b1)
            is_gate: begin
              gate_ok = (int'(bus.ins_dst) >= N_IN) &&
                        in_rng(bus.ins_dst) &&
                        in_rng(bus.ins_a) &&
                        in_rng(src_b);
              bad = !gate_ok;
              if (gate_ok) state_nx = EVAL;
            end
            is_out: begin
              out_ok = (int'(bus.ins_dst) < N_OUT) &&
                       in_rng(bus.ins_a);
              bad = !out_ok;
            end
            default: state_nx = DONE;
          endcase
        end
      end
      EVAL: state_nx = FETCH;
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells       <= '0;
      bus.out_vec <= '0;
      bus.err     <= 1'b0;
      dst_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      if (in_acc) begin
        cells <= {{(N_CELLS-N_IN){1'b0}},
                  bus.in_vec};
        bus.out_vec <= '0;
        bus.err     <= 1'b0;
      end
      if (bad) bus.err <= 1'b1;
      // INIT phase: precharge dst so EVAL sees it
      if (gate_ok) begin
        cells[bus.ins_dst] <= 1'b1;
        dst_q <= bus.ins_dst;
        a_q   <= bus.ins_a;
        b_q   <= src_b;
      end
      if (out_ok) begin
        for (int k = 0; k < N_OUT; k++) begin
          if (int'(bus.ins_dst) == k)
            bus.out_vec[k] <= cells[bus.ins_a];
        end
      end
      if (state == EVAL)
        cells[dst_q] <= ~(cells[a_q] | cells[b_q]);
    end
  end

`ifdef MAGIC_NOR_OPCOUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_count <= '0;
    else if (in_acc)
      op_count <= '0;
    else if (gate_ok && op_count != 16'hFFFF)
      op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_magic_nor_seq.sv
// tb_magic_nor_seq: directed-vector bench for magic_nor_seq
// covers reset, program k, write-protect, aliasing, backpressure, stall
module tb_magic_nor_seq;
  localparam int N_IN    = 10;
  localparam int N_OUT   = 7;
  localparam int N_CELLS = 64;
  localparam int ADDR_W  = 6;

  localparam logic [1:0] NOR = 2'b00;
  localparam logic [1:0] INV = 2'b01;
  localparam logic [1:0] OUT = 2'b10;
  localparam logic [1:0] ENP = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int c0 = 0;
  int lat = 0;

  magic_nor_seq_if #(
    .N_IN(N_IN), .N_OUT(N_OUT), .ADDR_W(ADDR_W)
  ) bus ();

`ifdef MAGIC_NOR_OPCOUNT_EN
  logic [15:0] op_count;
`endif

  magic_nor_seq #(
    .N_IN(N_IN), .N_OUT(N_OUT),
    .N_CELLS(N_CELLS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef MAGIC_NOR_OPCOUNT_EN
    ,
    .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_in(input logic [N_IN-1:0] v);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    tick();
    bus.in_valid = 1'b0;
    bus.in_vec   = '1;
    c0 = cyc;
  endtask

  task automatic send_ins(input logic [1:0] op,
                          input int dst,
                          input int a,
                          input int b);
    int n = 0;
    bus.ins_valid = 1'b1;
    bus.ins_op    = op;
    bus.ins_dst   = ADDR_W'(dst);
    bus.ins_a     = ADDR_W'(a);
    bus.ins_b     = ADDR_W'(b);
    while (!bus.ins_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.ins_ready)
      chk("ins_ready_timeout", 0, 1);
    tick();
  endtask

  task automatic wait_out();
    int n = 0;
    bus.ins_valid = 1'b0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("out_valid", 32'(bus.out_valid), 1);
    lat = cyc - c0;
  endtask

  task automatic take_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("rel_in_ready", 32'(bus.in_ready), 1);
    chk("rel_out_valid", 32'(bus.out_valid), 0);
  endtask

  // program k: k = j | ~h | ~i, to out_vec[0]
  task automatic prog_k(input bit stall);
    int n = 0;
    send_ins(INV, 10, 8, 0);
    send_ins(INV, 11, 7, 0);
    send_ins(NOR, 12, 9, 11);
    if (stall) begin
      bus.ins_valid = 1'b0;
      while (!bus.ins_ready && n < 10) begin
        tick();
        n++;
      end
      for (int i = 0; i < 3; i++) begin
        chk("stall_busy", 32'(bus.busy), 1);
        chk("stall_ins_ready",
            32'(bus.ins_ready), 1);
        tick();
      end
    end
    send_ins(INV, 13, 12, 0);
    send_ins(NOR, 14, 13, 10);
    send_ins(INV, 15, 14, 0);
    send_ins(OUT, 0, 15, 0);
    send_ins(ENP, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.ins_valid = 1'b0;
    bus.ins_op    = '0;
    bus.ins_dst   = '0;
    bus.ins_a     = '0;
    bus.ins_b     = '0;
    bus.out_ready = 1'b0;

    repeat (2) tick();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_ins_ready", 32'(bus.ins_ready), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_out_vec", 32'(bus.out_vec), 0);
    rst_n = 1'b1;
    tick();

    // k, h=i=1, j=0
    send_in(10'h180);
    chk("k1_busy", 32'(bus.busy), 1);
    prog_k(1'b0);
    wait_out();
    chk("k1_out", 32'(bus.out_vec), 32'h00);
    chk("k1_lat", lat, 14);
    chk("k1_err", 32'(bus.err), 0);
`ifdef MAGIC_NOR_OPCOUNT_EN
    chk("k1_opcnt", 32'(op_count), 6);
`endif
    take_out();

    // k, all zero
    send_in(10'h000);
    prog_k(1'b0);
    wait_out();
    chk("k0_out", 32'(bus.out_vec), 32'h01);
    chk("k0_lat", lat, 14);
    take_out();

    // stall: same result, 3 extra cycles
    send_in(10'h000);
    prog_k(1'b1);
    wait_out();
    chk("stall_out", 32'(bus.out_vec), 32'h01);
    chk("stall_lat", lat, 17);
    take_out();

    // write-protect and illegal OUT
    send_in(10'h008);
    send_ins(NOR, 3, 3, 3);
    chk("wp_err", 32'(bus.err), 1);
    chk("wp_1cyc", 32'(bus.ins_ready), 1);
    send_ins(OUT, 7, 3, 0);
    send_ins(INV, 9, 0, 0);
    send_ins(INV, 10, 0, 0);
    send_ins(OUT, 1, 3, 0);
    send_ins(OUT, 5, 10, 0);
    send_ins(OUT, 6, 9, 0);
    send_ins(ENP, 0, 0, 0);
    wait_out();
    chk("wp_out", 32'(bus.out_vec), 32'h22);
    chk("wp_err_sticky", 32'(bus.err), 1);
`ifdef MAGIC_NOR_OPCOUNT_EN
    chk("wp_opcnt", 32'(op_count), 1);
`endif
    take_out();

    // aliased operands read post-INIT value
    send_in(10'h000);
    chk("al_err_clr", 32'(bus.err), 0);
    chk("al_out_clr", 32'(bus.out_vec), 0);
    send_ins(INV, 20, 0, 0);
    send_ins(OUT, 2, 20, 0);
    send_ins(NOR, 20, 20, 20);
    send_ins(OUT, 3, 20, 0);
    send_ins(INV, 21, 21, 0);
    send_ins(OUT, 4, 21, 0);
    send_ins(ENP, 0, 0, 0);
    wait_out();
    chk("al_out", 32'(bus.out_vec), 32'h04);
    chk("al_err", 32'(bus.err), 0);
`ifdef MAGIC_NOR_OPCOUNT_EN
    chk("al_opcnt", 32'(op_count), 3);
`endif
    take_out();

    // backpressure with ignored in_valid
    send_in(10'h000);
    prog_k(1'b0);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_vec", 32'(bus.out_vec), 32'h01);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      bus.in_valid = 1'b1;
      bus.in_vec   = 10'h180;
      tick();
    end
    bus.in_valid = 1'b0;
    take_out();
    chk("bp_idle_busy", 32'(bus.busy), 0);

    // reset mid-EVAL
    send_in(10'h100);
    send_ins(OUT, 0, 8, 0);
    send_ins(OUT, 7, 0, 0);
    send_ins(INV, 10, 8, 0);
    chk("mr_pre_busy", 32'(bus.busy), 1);
    chk("mr_pre_err", 32'(bus.err), 1);
    chk("mr_pre_out", 32'(bus.out_vec), 32'h01);
    bus.ins_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(bus.busy), 0);
    chk("mr_out", 32'(bus.out_vec), 0);
    chk("mr_err", 32'(bus.err), 0);
    chk("mr_in_ready", 32'(bus.in_ready), 1);
    chk("mr_ins_ready", 32'(bus.ins_ready), 0);
    chk("mr_out_valid", 32'(bus.out_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_in(10'h000);
    prog_k(1'b0);
    wait_out();
    chk("mr_k_out", 32'(bus.out_vec), 32'h01);
    chk("mr_k_lat", lat, 14);
    take_out();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
